// File: rtl/fetch_unit.sv
// fetch_unit: dual-issue fetch stage. Owns the fetch PC, requests 8-byte
// instruction pairs from instruction memory and buffers returned pairs in an
// in-order queue that feeds the IF/ID pipeline register.
//
// Handshake semantics (both memory channels): a request transfers on a rising
// clk edge where imem_req_valid && imem_req_ready; while valid is high and
// ready is low, imem_req_addr holds steady. A redirect withdraws an unaccepted
// request. Responses have no ready: imem_resp_valid presents one pair that is
// consumed in that cycle, one per accepted request, in request order.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data0,
    input  logic [31:0] imem_resp_data1,
    output logic [31:0] pc_out,
    output logic [31:0] instr0_out,
    output logic [31:0] instr1_out,
    output logic        fetch_valid
);

    localparam int          PW  = $clog2(QDEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Architectural fetch state
    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;

    // Fetch queue of {pc, i0, i1}
    logic [31:0]   q_pc [QDEPTH];
    logic [31:0]   q_i0 [QDEPTH];
    logic [31:0]   q_i1 [QDEPTH];
    logic [PW-1:0] q_rd;
    logic [PW-1:0] q_wr;

    // Addresses of outstanding requests, so each response knows its PC
    logic [31:0]   pf_mem [QDEPTH];
    logic [PW-1:0] pf_rd;
    logic [PW-1:0] pf_wr;

    logic [CW:0] credit_used;
    logic        accept;
    logic        resp_keep;
    logic        pop;

    // Queued pairs plus in-flight requests never exceed the queue depth, so
    // every kept response is guaranteed a free slot.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = reset_n && !redirect_valid &&
                            (credit_used < (CW+1)'(QDEPTH));
    assign imem_req_addr  = fetch_pc;

    assign accept    = imem_req_valid && imem_req_ready;
    assign resp_keep = imem_resp_valid && !redirect_valid && (discard == '0);
    // count is registered, so a pair written this cycle is not popped until next
    assign pop       = (count != '0) && !stall && !redirect_valid;

    // Control state: PC, counters and pointers; redirect overrides queue activity
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            pf_rd       <= '0;
            pf_wr       <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(imem_resp_valid);
            if (accept)          pf_wr <= pf_wr + 1'b1;
            if (imem_resp_valid) pf_rd <= pf_rd + 1'b1;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                count    <= '0;
                q_rd     <= '0;
                q_wr     <= '0;
                // everything still in flight belongs to the old path
                discard  <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (accept)                            fetch_pc <= fetch_pc + 32'd8;
                if (imem_resp_valid && discard != '0)  discard  <= discard - 1'b1;
                if (resp_keep)                         q_wr     <= q_wr + 1'b1;
                if (pop)                               q_rd     <= q_rd + 1'b1;
                count <= count + CW'(resp_keep) - CW'(pop);
            end
        end
    end

    // Storage writes: queue entries on kept responses, request PCs on accept
    always_ff @(posedge clk) begin
        if (resp_keep) begin
            q_pc[q_wr] <= pf_mem[pf_rd];
            q_i0[q_wr] <= imem_resp_data0;
            q_i1[q_wr] <= imem_resp_data1;
        end
        if (accept) begin
            pf_mem[pf_wr] <= fetch_pc;
        end
    end

    // Head presentation: NOP bubble when empty or being flushed
    always_comb begin
        fetch_valid = 1'b0;
        pc_out      = 32'h0;
        instr0_out  = NOP;
        instr1_out  = NOP;
        if (count != '0 && !redirect_valid) begin
            fetch_valid = 1'b1;
            pc_out      = q_pc[q_rd];
            instr0_out  = q_i0[q_rd];
            instr1_out  = q_i1[q_rd];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit with a behavioural memory
// model and a scoreboard of expected output PCs.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          QDEPTH   = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data0 = 32'h0;
    logic [31:0] imem_resp_data1 = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] instr0_out;
    logic [31:0] instr1_out;
    logic        fetch_valid;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data0 (imem_resp_data0),
        .imem_resp_data1 (imem_resp_data1),
        .pc_out          (pc_out),
        .instr0_out      (instr0_out),
        .instr1_out      (instr1_out),
        .fetch_valid     (fetch_valid)
    );

    // ---------------- reference model state ----------------
    logic [31:0] exp_q [$];      // accepted on current path, not yet popped
    pend_t       pending [$];    // memory: accepted, not yet responded
    logic [31:0] model_pc;
    int          ready_pairs;    // kept responses waiting in the queue
    int          stale_cnt;      // responses still owed to a flushed path
    int          cyc;
    int          lat;
    int          first_fv_cyc;
    logic [31:0] prev_pop_pc;
    logic        wrap_seen;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset_n         = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b1;
        pending.delete();
        exp_q.delete();
        ready_pairs  = 0;
        stale_cnt    = 0;
        model_pc     = RESET_PC;
        first_fv_cyc = -1;
        prev_pop_pc  = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        cyc     = 0;
        reset_n = 1'b1;
    endtask

    // One cycle of stimulus: drive inputs shortly after the rising edge and
    // present the oldest memory response once its latency has elapsed.
    task automatic run_cycle(input logic rdy, input logic stl, input logic rdr, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        cyc++;
        imem_req_ready = rdy;
        stall          = stl;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data0 = mem_word(pending[0].addr);
            imem_resp_data1 = mem_word(pending[0].addr + 32'd4);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data0 = $urandom;
            imem_resp_data1 = $urandom;
        end
    endtask

    // ---------------- model update (after the monitor has sampled) ----------------
    always @(negedge clk) begin
        #1;
        if (reset_n) begin
            automatic int  n_out = pending.size();
            automatic logic resp = imem_resp_valid;
            automatic logic acc  = imem_req_valid && imem_req_ready;
            if (resp && n_out > 0) void'(pending.pop_front());
            if (redirect_valid) begin
                stale_cnt   = n_out - (resp ? 1 : 0);
                ready_pairs = 0;
                exp_q.delete();
                model_pc    = redirect_pc;
            end else begin
                if (resp) begin
                    if (stale_cnt > 0) stale_cnt--;
                    else               ready_pairs++;
                end
                if (acc) begin
                    pending.push_back('{addr: model_pc, due: cyc + lat});
                    exp_q.push_back(model_pc);
                    model_pc = model_pc + 32'd8;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset_n) begin
            check("reset_outputs",
                  {imem_req_valid, fetch_valid, pc_out, instr0_out, instr1_out},
                  {1'b0, 1'b0, 32'h0, NOP, NOP});
        end else begin
            automatic logic exp_rv = !redirect_valid && (ready_pairs + pending.size() < QDEPTH);
            automatic logic exp_fv = !redirect_valid && (ready_pairs > 0);
            check("req_valid", imem_req_valid, exp_rv);
            if (exp_rv) check("req_addr", imem_req_addr, model_pc);
            check("fetch_valid", fetch_valid, exp_fv);
            if (fetch_valid && first_fv_cyc < 0) first_fv_cyc = cyc;
            if (exp_fv && exp_q.size() > 0) begin
                check("head_pair", {pc_out, instr0_out, instr1_out},
                      {exp_q[0], mem_word(exp_q[0]), mem_word(exp_q[0] + 32'd4)});
                if (!stall) begin
                    if (prev_pop_pc == 32'hFFFF_FFF8 && pc_out == 32'h0) wrap_seen = 1'b1;
                    prev_pop_pc = pc_out;
                    void'(exp_q.pop_front());
                    ready_pairs--;
                end
            end else if (!exp_fv) begin
                check("idle_outputs", {pc_out, instr0_out, instr1_out}, {32'h0, NOP, NOP});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic hit;
        lat       = 1;
        cyc       = 0;
        wrap_seen = 1'b0;

        // streaming from RESET_PC, 1-cycle memory
        do_reset();
        repeat (20) run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("first_fetch_valid_cycle", 32'(first_fv_cyc), 32'd2);

        // reset mid-stream, then hold stall so the queue fills, then drain
        do_reset();
        repeat (10) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (15) run_cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // redirect with three requests in flight on a 3-cycle memory
        lat = 3;
        hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
            if (pending.size() == 3) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_2000;
                hit = 1'b1;
                break;
            end
        end
        check("redirect_with_3_outstanding", hit, 1'b1);
        repeat (15) run_cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // redirect coinciding with a response and a pop, 1-cycle memory
        lat = 1;
        repeat (8) run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b0, 1'b1, 32'h0000_3000);
        repeat (10) run_cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // address wrap at the top of the address space
        run_cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0);
        repeat (12) run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("pc_wrap_to_zero", wrap_seen, 1'b1);

        // random backpressure, stalls, latencies and redirects
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 4);
            run_cycle($urandom_range(0, 3) != 0,
                      $urandom_range(0, 4) == 0,
                      $urandom_range(0, 30) == 0,
                      $urandom & 32'hFFFF_FFFC);
        end
        repeat (20) run_cycle(1'b1, 1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
